// File: rtl/seg7_msg_pkg.sv
// Shared constants, glyph table and state type for the 7-segment message sequencer.
package seg7_msg_pkg;

    localparam int SEG_DP = 7;
    localparam int SEG_A  = 6;
    localparam int SEG_B  = 5;
    localparam int SEG_C  = 4;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 2;
    localparam int SEG_F  = 1;
    localparam int SEG_G  = 0;

    localparam logic [7:0] GLYPH_DP    = 8'h80;
    localparam logic [7:0] GLYPH_S     = 8'h5B;
    localparam logic [7:0] GLYPH_E     = 8'h4F;
    localparam logic [7:0] GLYPH_N     = 8'h15;
    localparam logic [7:0] GLYPH_O     = 8'h7E;
    localparam logic [7:0] GLYPH_L     = 8'h0E;
    localparam logic [7:0] GLYPH_G     = 8'h5F;
    localparam logic [7:0] GLYPH_U     = 8'h3E;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

    localparam int MSG_TABLE_LEN = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Message: DP S E n O L G U L G O n U L; anything past the table is blank.
    function automatic logic [7:0] msg_glyph(input logic [31:0] idx);
        logic [7:0] g;
        case (idx)
            32'd0:   g = GLYPH_DP;
            32'd1:   g = GLYPH_S;
            32'd2:   g = GLYPH_E;
            32'd3:   g = GLYPH_N;
            32'd4:   g = GLYPH_O;
            32'd5:   g = GLYPH_L;
            32'd6:   g = GLYPH_G;
            32'd7:   g = GLYPH_U;
            32'd8:   g = GLYPH_L;
            32'd9:   g = GLYPH_G;
            32'd10:  g = GLYPH_O;
            32'd11:  g = GLYPH_N;
            32'd12:  g = GLYPH_U;
            32'd13:  g = GLYPH_L;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_step_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, debounce counter and rising-edge pulse.
module seg7_step_conditioner
    import seg7_msg_pkg::*;
#(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step_in,
    output logic step_p
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1_r;
    logic            sync2_r;
    logic            level_r;
    logic            level_d_r;
    logic [DB_W-1:0] db_cnt_r;

    // Two-stage synchroniser for the raw asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= step_in;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r  <= {DB_W{1'b0}};
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
        end else begin
            level_d_r <= level_r;
            if (sync2_r != level_r) begin
                if (db_cnt_r == DB_LAST) begin
                    level_r  <= sync2_r;
                    db_cnt_r <= {DB_W{1'b0}};
                end else begin
                    db_cnt_r <= db_cnt_r + DB_W'(1);
                end
            end else begin
                db_cnt_r <= {DB_W{1'b0}};
            end
        end
    end

    // Decoded straight from registers so the sequencer reacts on the very next edge.
    assign step_p = level_r & ~level_d_r;

endmodule

// File: rtl/seg7_msg_sequencer.sv
// 7-segment message sequencer: manual/auto advance, pause, reverse and play-once modes.
module seg7_msg_sequencer
    import seg7_msg_pkg::*;
#(
    parameter  int MSG_LEN   = 14,
    parameter  int DB_CYCLES = 50000,
    parameter  int AUTO_DIV  = 10000000,
    localparam int IDX_W     = $clog2(MSG_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_in,
    input  logic             mode_auto,
    input  logic             dir_rev,
    input  logic             once,
    output logic [7:0]       seg_out,
    output logic [IDX_W-1:0] index_out,
    output logic             wrap_o,
    output logic             done_o
);

    localparam int TICK_W = $clog2(AUTO_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(AUTO_DIV - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MSG_LEN - 1);
    localparam logic [IDX_W-1:0]  FIRST_IDX = {IDX_W{1'b0}};

    logic              step_p_s;
    logic              tick_s;
    logic              adv_s;
    logic              at_end_s;
    logic [IDX_W-1:0]  idx_step_s;
    logic [IDX_W-1:0]  start_idx_s;
    logic [TICK_W-1:0] tick_cnt_r;
    state_t            state_r;
    logic [IDX_W-1:0]  idx_r;
    logic [7:0]        seg_r;
    logic              wrap_r;
    logic              done_r;

    seg7_step_conditioner #(
        .DB_CYCLES (DB_CYCLES)
    ) u_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_in (step_in),
        .step_p  (step_p_s)
    );

    assign tick_s      = (state_r == SHOW) && mode_auto && (tick_cnt_r == TICK_LAST);
    assign adv_s       = mode_auto ? tick_s : step_p_s;
    assign at_end_s    = dir_rev ? (idx_r == FIRST_IDX) : (idx_r == LAST_IDX);
    assign start_idx_s = dir_rev ? LAST_IDX : FIRST_IDX;

    // Next index in the current direction, wrapping modulo MSG_LEN rather than 2^IDX_W.
    always_comb begin
        idx_step_s = idx_r;
        if (at_end_s) begin
            idx_step_s = dir_rev ? LAST_IDX : FIRST_IDX;
        end else if (dir_rev) begin
            idx_step_s = idx_r - IDX_W'(1);
        end else begin
            idx_step_s = idx_r + IDX_W'(1);
        end
    end

    // Auto-advance prescaler; runs only while showing in auto mode, otherwise parked at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if ((state_r == SHOW) && mode_auto) begin
            if (tick_s) begin
                tick_cnt_r <= {TICK_W{1'b0}};
            end else begin
                tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
        end else begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end
    end

    // Sequencer FSM; seg/index are registered from the index being moved to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= FIRST_IDX;
            seg_r   <= GLYPH_BLANK;
            wrap_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (adv_s || step_p_s) begin
                        state_r <= SHOW;
                        idx_r   <= start_idx_s;
                        seg_r   <= msg_glyph(32'(start_idx_s));
                    end else begin
                        seg_r   <= GLYPH_BLANK;
                    end
                end
                SHOW: begin
                    // A press in auto mode pauses, even if a tick lands in the same cycle.
                    if (mode_auto && step_p_s) begin
                        state_r <= PAUSED;
                    end else if (adv_s) begin
                        if (at_end_s && once) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            idx_r  <= idx_step_s;
                            seg_r  <= msg_glyph(32'(idx_step_s));
                            wrap_r <= at_end_s;
                        end
                    end
                end
                PAUSED: begin
                    if (step_p_s || !mode_auto) begin
                        state_r <= SHOW;
                    end
                end
                DONE: begin
                    if (step_p_s) begin
                        state_r <= IDLE;
                        idx_r   <= FIRST_IDX;
                        seg_r   <= GLYPH_BLANK;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= FIRST_IDX;
                    seg_r   <= GLYPH_BLANK;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign seg_out   = seg_r;
    assign index_out = idx_r;
    assign wrap_o    = wrap_r;
    assign done_o    = done_r;

endmodule

// File: tb/tb_seg7_msg_sequencer.sv
// Self-checking bench for seg7_msg_sequencer against an event-level message model.
module tb_seg7_msg_sequencer;

    localparam int LEN = 14;
    localparam int DB  = 4;
    localparam int DIV = 8;

    typedef enum {M_BLANK, M_RUN, M_END} mstate_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       step_in   = 1'b0;
    logic       mode_auto = 1'b0;
    logic       dir_rev   = 1'b0;
    logic       once      = 1'b0;
    logic [7:0] seg_out;
    logic [3:0] index_out;
    logic       wrap_o;
    logic       done_o;

    int checks    = 0;
    int errors    = 0;
    int wrap_seen = 0;
    int wrap_exp  = 0;

    mstate_t m_st  = M_BLANK;
    int      m_idx = 0;
    logic [7:0] gly [LEN] = '{8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F,
                              8'h3E, 8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E};

    always #5 clk = ~clk;

    seg7_msg_sequencer #(
        .MSG_LEN   (LEN),
        .DB_CYCLES (DB),
        .AUTO_DIV  (DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_in   (step_in),
        .mode_auto (mode_auto),
        .dir_rev   (dir_rev),
        .once      (once),
        .seg_out   (seg_out),
        .index_out (index_out),
        .wrap_o    (wrap_o),
        .done_o    (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (wrap_o === 1'b1) wrap_seen++;
        end
    endtask

    function automatic logic [7:0] exp_seg();
        return (m_st == M_BLANK) ? 8'h00 : gly[m_idx];
    endfunction

    // One accepted button press, as seen at the message level.
    task automatic model_step();
        int nxt;
        bit wrapped;
        case (m_st)
            M_BLANK: begin
                m_st  = M_RUN;
                m_idx = dir_rev ? LEN - 1 : 0;
            end
            M_RUN: begin
                nxt     = (m_idx + (dir_rev ? LEN - 1 : 1)) % LEN;
                wrapped = dir_rev ? (nxt > m_idx) : (nxt < m_idx);
                if (wrapped && once) begin
                    m_st = M_END;
                end else begin
                    if (wrapped) wrap_exp++;
                    m_idx = nxt;
                end
            end
            M_END: begin
                m_st  = M_BLANK;
                m_idx = 0;
            end
            default: ;
        endcase
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_idx"}, 32'(index_out), 32'(m_idx));
        chk({tag, "_seg"}, 32'(seg_out), 32'(exp_seg()));
        chk({tag, "_done"}, 32'(done_o), 32'(m_st == M_END));
    endtask

    task automatic press(input int hi, input int lo);
        step_in = 1'b1;
        cyc(hi);
        step_in = 1'b0;
        cyc(lo);
        model_step();
    endtask

    task automatic press_timed(input string tag);
        logic [7:0] prev;
        prev    = seg_out;
        step_in = 1'b1;
        cyc(6);
        chk({tag, "_early"}, 32'(seg_out), 32'(prev));
        cyc(1);
        model_step();
        check_model(tag);
        cyc(3);
        step_in = 1'b0;
        cyc(10);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        chk("rst_seg", 32'(seg_out), 32'h0);
        chk("rst_idx", 32'(index_out), 32'h0);
        chk("rst_wrap", 32'(wrap_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        rst_n = 1'b1;
        cyc(2);
        m_st      = M_BLANK;
        m_idx     = 0;
        wrap_seen = 0;
        wrap_exp  = 0;
    endtask

    initial begin
        int hold;
        bit moved;

        @(negedge clk);
        do_reset();

        // Clean presses with exact 7-cycle latency.
        press_timed("p0");
        press_timed("p1");
        press_timed("p2");
        chk("p2_seg_lit", 32'(seg_out), 32'h4F);

        // Bounce: two short high bursts are rejected, a long hold is one step.
        step_in = 1'b1; cyc(3);
        step_in = 1'b0; cyc(1);
        step_in = 1'b1; cyc(3);
        check_model("bounce_hold");
        cyc(6);
        step_in = 1'b0;
        cyc(10);
        model_step();
        check_model("bounce_accept");

        // Loop wrap forward across 15 presses.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            press($urandom_range(6, 12), $urandom_range(6, 12));
            check_model("wrap_fwd");
        end
        chk("wrap_last_seg", 32'(seg_out), 32'h80);
        chk("wrap_pulses", 32'(wrap_seen), 32'd1);

        // Reverse through index 0 to the last entry.
        press(10, 10);
        dir_rev = 1'b1;
        press(10, 10);
        check_model("rev_0");
        press(10, 10);
        check_model("rev_13");
        chk("rev_wrap_pulses", 32'(wrap_seen), 32'(wrap_exp));
        do_reset();
        press(10, 10);
        check_model("rev_start");

        // Random manual walk with random direction and occasional play-once.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            dir_rev = 1'($urandom_range(0, 1));
            once    = ($urandom_range(0, 3) == 0);
            press($urandom_range(6, 12), $urandom_range(6, 12));
            check_model("rand_walk");
        end
        chk("rand_wrap_pulses", 32'(wrap_seen), 32'(wrap_exp));

        // Auto mode: advance every DIV cycles, pause on a tick cycle, resume.
        do_reset();
        dir_rev = 1'b0;
        once    = 1'b0;
        press(10, 10);
        mode_auto = 1'b1;
        for (int i = 0; i < int'($urandom_range(2, 4)); i++) begin
            cyc(DIV - 1);
            check_model("auto_wait");
            cyc(1);
            model_step();
            check_model("auto_adv");
        end
        cyc(1);
        step_in = 1'b1;
        cyc(7);
        check_model("pause_on_tick");
        cyc(3);
        step_in = 1'b0;
        hold  = $urandom_range(10, 40);
        moved = 1'b0;
        for (int i = 0; i < hold; i++) begin
            cyc(1);
            if (index_out !== 4'(m_idx)) moved = 1'b1;
        end
        chk("paused_frozen", 32'(moved), 32'd0);
        step_in = 1'b1;
        cyc(7);
        check_model("resume_edge");
        cyc(3);
        step_in = 1'b0;
        cyc(4);
        check_model("resume_wait");
        cyc(1);
        model_step();
        check_model("resume_adv");
        mode_auto = 1'b0;
        cyc(2);

        // Play-once in auto mode from index 10 stops on the last glyph.
        do_reset();
        for (int i = 0; i < 11; i++) press($urandom_range(6, 9), $urandom_range(6, 9));
        check_model("once_start");
        once      = 1'b1;
        mode_auto = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(DIV);
            model_step();
            check_model("once_run");
        end
        chk("once_done_lit", 32'(done_o), 32'd1);
        once = 1'b0;
        cyc(20);
        check_model("done_hold");
        press(10, 10);
        check_model("done_exit");
        mode_auto = 1'b0;

        // Asynchronous reset mid-message.
        press(10, 10);
        check_model("pre_async");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_seg", 32'(seg_out), 32'h0);
        chk("async_idx", 32'(index_out), 32'h0);
        chk("async_done", 32'(done_o), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
